alu_seq: RTL

- Parametrised, registered successor to the processor's 8-bit combinational ALU. Used as the execute unit of the 16-bit processor datapath.
- Keeps opcodes 1..6 bit-compatible with the existing ALU encoding.
- Adds shifts, add/subtract with carry, compare, and an iterative shift-add multiply.
- Adds a persistent flag register and valid/ready handshakes on both input and output.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_mul_iter.sv | 80 ++++++++
 rtl/alu_seq.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential execute unit. The processor decoder
// imports the same opcode constants, so opcodes 1..6 keep the encoding of
// the older combinational ALU.
//   OP_*      4-bit opcode values
//   state_e   control state of the execute unit
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_SHL = 4'd7;
    localparam logic [3:0] OP_SHR = 4'd8;
    localparam logic [3:0] OP_ADC = 4'd9;
    localparam logic [3:0] OP_SBB = 4'd10;
    localparam logic [3:0] OP_CMP = 4'd11;
    localparam logic [3:0] OP_MUL = 4'd12;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// ---------------------------------------------------------------------------
// alu_mul_iter
// Iterative shift-add unsigned multiplier, one partial product per cycle.
//   clk, rst_n   clock, asynchronous active-low reset
//   start        latch a/b and begin a new multiplication
//   a, b         operands (sampled only when start is high)
//   done         high during the cycle that performs the final step
//   product      accumulator value after the current cycle's step
// ---------------------------------------------------------------------------
module alu_mul_iter #(
    parameter  int WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    logic               busy_q,   busy_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [2*WIDTH-1:0] mcand_q,  mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q,    acc_d;
    logic [2*WIDTH-1:0] step_sum;
    logic               last_step;

    // The multiplicand walks left while the multiplier walks right, so
    // every step only has to look at the multiplier's LSB.
    assign step_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign last_step = busy_q && (cnt_q == CNT_W'(WIDTH - 1));

    // Exposing the post-step sum (not acc_q) lets the parent capture the
    // finished product on the same edge as the last step.
    assign done    = last_step;
    assign product = step_sum;

    always_comb begin
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        if (start) begin
            busy_d   = 1'b1;
            cnt_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
        end else if (busy_q) begin
            acc_d    = step_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (last_step) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq
// Registered execute unit with valid/ready handshakes, persistent flags and
// an iterative multiplier.
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   request handshake (a, b, op sampled on accept)
//   a, b, op              operands and opcode (b[CNT_W-1:0] is shift amount)
//   out_valid / out_ready result handshake
//   result, result_hi     result; result_hi is the product high half for MUL
//   flag_c/z/n/v          carry/borrow, zero, negative, signed overflow
// ---------------------------------------------------------------------------
module alu_seq
    import alu_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v
);

    localparam int MSB = WIDTH - 1;

    state_e             state_q, state_d;
    logic               accept;
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   result_q,    result_d;
    logic [WIDTH-1:0]   result_hi_q, result_hi_d;
    logic               flag_c_q,    flag_c_d;
    logic               flag_z_q,    flag_z_d;
    logic               flag_n_q,    flag_n_d;
    logic               flag_v_q,    flag_v_d;

    logic               add_cin;
    logic               sub_bin;
    logic [WIDTH:0]     add_ext;
    logic [WIDTH:0]     sub_ext;
    logic [CNT_W-1:0]   shamt;
    logic [2*WIDTH-1:0] shl_ext;
    logic [2*WIDTH-1:0] shr_ext;
    logic [WIDTH-1:0]   alu_res;
    logic [WIDTH-1:0]   alu_fsrc;
    logic               alu_c;
    logic               alu_v;

    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: MUL is the only multi-cycle op.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept && (op == OP_MUL)) state_d = ST_MUL;
            ST_MUL:  if (mul_done)                 state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs. A request may be taken in the same cycle the held
    // result is consumed; rst_n gates in_ready so nothing is taken in reset.
    always_comb begin
        in_ready  = rst_n && (state_q == ST_IDLE) && (!out_valid_q || out_ready);
        accept    = in_valid && in_ready;
        mul_start = accept && (op == OP_MUL);
    end

    // Single-cycle datapath. Arithmetic runs at WIDTH+1 bits so the top bit
    // is the carry (add) or borrow (subtract). Shifts are done in a 2*WIDTH
    // field so the last bit shifted out lands at a fixed position.
    always_comb begin
        add_cin = (op == OP_ADC) && flag_c_q;
        sub_bin = (op == OP_SBB) && flag_c_q;
        add_ext = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, add_cin};
        sub_ext = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, sub_bin};
        shamt   = b[CNT_W-1:0];
        shl_ext = {{WIDTH{1'b0}}, a} << shamt;
        shr_ext = {a, {WIDTH{1'b0}}} >> shamt;

        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            OP_NOP: alu_res = '0;
            OP_ADD, OP_ADC: begin
                alu_res = add_ext[MSB:0];
                alu_c   = add_ext[WIDTH];
                alu_v   = (a[MSB] == b[MSB]) && (add_ext[MSB] != a[MSB]);
            end
            OP_SUB, OP_SBB, OP_CMP: begin
                alu_res = (op == OP_CMP) ? '0 : sub_ext[MSB:0];
                alu_c   = sub_ext[WIDTH];
                alu_v   = (a[MSB] != b[MSB]) && (sub_ext[MSB] != a[MSB]);
            end
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_NOT: alu_res = ~a;
            OP_XOR: alu_res = a ^ b;
            OP_SHL: begin
                if (shamt >= CNT_W'(WIDTH)) begin
                    alu_res = '0;
                end else begin
                    alu_res = shl_ext[MSB:0];
                    alu_c   = shl_ext[WIDTH];
                end
            end
            OP_SHR: begin
                if (shamt >= CNT_W'(WIDTH)) begin
                    alu_res = '0;
                end else begin
                    alu_res = shr_ext[2*WIDTH-1:WIDTH];
                    alu_c   = shr_ext[MSB];
                end
            end
            default: alu_res = '0;
        endcase

        // CMP discards the difference but still reports Z/N from it.
        alu_fsrc = (op == OP_CMP) ? sub_ext[MSB:0] : alu_res;
    end

    // Result/flag registers change only when a result is produced, which is
    // what makes flag_c persist between ADC/SBB chains.
    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        flag_c_d    = flag_c_q;
        flag_z_d    = flag_z_q;
        flag_n_d    = flag_n_q;
        flag_v_d    = flag_v_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept && (op != OP_MUL)) begin
            out_valid_d = 1'b1;
            result_d    = alu_res;
            result_hi_d = '0;
            flag_c_d    = alu_c;
            flag_v_d    = alu_v;
            flag_z_d    = (alu_fsrc == '0);
            flag_n_d    = alu_fsrc[MSB];
        end else if ((state_q == ST_MUL) && mul_done) begin
            out_valid_d = 1'b1;
            result_d    = mul_product[MSB:0];
            result_hi_d = mul_product[2*WIDTH-1:WIDTH];
            flag_c_d    = |mul_product[2*WIDTH-1:WIDTH];
            flag_v_d    = 1'b0;
            flag_z_d    = (mul_product[MSB:0] == '0);
            flag_n_d    = mul_product[MSB];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            flag_c_q    <= 1'b0;
            flag_z_q    <= 1'b0;
            flag_n_q    <= 1'b0;
            flag_v_q    <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            flag_c_q    <= flag_c_d;
            flag_z_q    <= flag_z_d;
            flag_n_q    <= flag_n_d;
            flag_v_q    <= flag_v_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign flag_c    = flag_c_q;
    assign flag_z    = flag_z_q;
    assign flag_n    = flag_n_q;
    assign flag_v    = flag_v_q;

endmodule
